// File: rtl/icache_tcm_responder_pkg.sv
// Shared constants and helpers for the instruction TCM responder and its requesters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icache_tcm_responder_pkg;

    // Data path is one 32-bit instruction word with one enable per byte.
    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    // Request tag layout: {uuid, wid}. The default widths add up to the
    // responder's default TAG_WIDTH of 8.
    localparam int WID_W  = 3;
    localparam int UUID_W = 5;
    localparam int TAG_W  = UUID_W + WID_W;

    function automatic logic [TAG_W-1:0] tag_pack(input logic [UUID_W-1:0] uuid,
                                                  input logic [WID_W-1:0]  wid);
        return {uuid, wid};
    endfunction

    function automatic logic [WID_W-1:0] tag_wid(input logic [TAG_W-1:0] tag);
        return tag[WID_W-1:0];
    endfunction

    function automatic logic [UUID_W-1:0] tag_uuid(input logic [TAG_W-1:0] tag);
        return tag[TAG_W-1:WID_W];
    endfunction

    // Width needed to count 0..depth inclusive.
    function automatic int pend_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/icache_tcm_rsp_queue.sv
// In-order response FIFO of {data, tag}; entry visible the cycle after its push.
// Latency: 1 cycle push-to-head when empty; no output register beyond that.
// Backpressure: pop only acts when non-empty, push is dropped when full (caller bounds occupancy).
// Ports: clk/reset, push_i/push_dat_i, pop_i, pop_dat_o (head entry), empty_o, full_o.
module icache_tcm_rsp_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_dat_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/icache_tcm_responder.sv
// Instruction-cache responder: serves tagged word reads from an on-chip TCM, applies byte-enabled writes.
// Latency: LATENCY cycles from read accept to earliest rsp_valid; 1 response/cycle sustained.
// Backpressure: req_ready is a registered function of the outstanding-read count (limit RSP_QUEUE_SIZE).
// Ports: req_* request channel (valid/ready), rsp_* response channel (valid/ready, in order, tag echoed),
//        err_oob sticky flag for any accepted access at or beyond SIZE.
module icache_tcm_responder
    import icache_tcm_responder_pkg::*;
#(
    parameter int SIZE           = 1024,
    parameter int ADDR_WIDTH     = 30,
    parameter int TAG_WIDTH      = 8,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_rw,
    input  logic [BE_W-1:0]       req_byteen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_W-1:0]     req_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [WORD_W-1:0]     rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  rsp_ready,
    output logic                  err_oob
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PW = pend_width(RSP_QUEUE_SIZE);
    localparam int QW = WORD_W + TAG_WIDTH;

    logic [WORD_W-1:0] mem_q [SIZE];

    logic          req_ready_q;
    logic [PW-1:0] pending_q;
    logic [PW-1:0] pending_d;
    logic          err_oob_q;

    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              oob;
    logic [IW-1:0]     idx;
    logic [WORD_W-1:0] rd_word;
    logic              rsp_fire;

    logic          push_vld;
    logic [QW-1:0] push_dat;
    logic [QW-1:0] head_dat;
    logic          q_empty;
    logic          q_full;

    assign acc    = req_valid && req_ready;
    assign rd_acc = acc && !req_rw;
    assign wr_acc = acc && req_rw;
    assign oob    = (req_addr >= ADDR_WIDTH'(SIZE));
    assign idx    = req_addr[IW-1:0];

    // Out-of-range reads return zero rather than aliased TCM contents.
    assign rd_word = oob ? '0 : mem_q[idx];

    // Gating with reset keeps the reset cycle itself from accepting anything.
    assign req_ready = req_ready_q && !reset;
    assign rsp_valid = !q_empty;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign {rsp_data, rsp_tag} = head_dat;
    assign err_oob   = err_oob_q;

    // Pipeline stages are counted in pending, so the queue can never overflow
    // and the stages themselves never need to stall.
    assign pending_d = pending_q + PW'(rd_acc) - PW'(rsp_fire);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            req_ready_q <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            req_ready_q <= (pending_d < PW'(RSP_QUEUE_SIZE));
            err_oob_q   <= err_oob_q || (acc && oob);
        end
    end

    // TCM is not reset. A write lands at its accept edge, so any later read sees it.
    always_ff @(posedge clk) begin
        if (wr_acc && !oob) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_byteen[i]) begin
                    mem_q[idx][8*i +: 8] <= req_data[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: the queue push happens at the end of accept cycle + LATENCY - 1.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign push_vld = rd_acc;
            assign push_dat = {rd_word, req_tag};
        end else begin : g_lat2
            logic          s1_vld_q;
            logic [QW-1:0] s1_dat_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_vld_q <= 1'b0;
                end else begin
                    s1_vld_q <= rd_acc;
                end
                s1_dat_q <= {rd_word, req_tag};
            end

            assign push_vld = s1_vld_q;
            assign push_dat = s1_dat_q;
        end
    endgenerate

    icache_tcm_rsp_queue #(
        .DEPTH (RSP_QUEUE_SIZE),
        .DW    (QW)
    ) u_rsp_queue (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push_vld),
        .push_dat_i (push_dat),
        .pop_i      (rsp_fire),
        .pop_dat_o  (head_dat),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

endmodule
